maple_port_phy: RTL and testbench
=================================

// Module: maple_port_phy
// PURPOSE
//  Multi-port Maple Bus physical layer between one transmitter/receiver pair and NUM_PORTS open-drain SDCKA/SDCKB pin pairs.
//  Adds the following over the single-port controller top:
//   - a port selector latched per transaction
//   - input synchronisers and a glitch filter
//   - a host-send / device-response turnaround FSM with response timeout
//   - per-port open-drain enables
//   - a loopback mode
//  Sits between the control-register block, the transmitter/receiver and the top-level pin tristates.
// PARAMETERS
//  NUM_PORTS   4   number of Maple pin pairs
//  PORT_W      2   port index width, equal to $clog2(NUM_PORTS); minimum 1
//  SYNC_STAGES 2   synchroniser flops per pin, minimum 2
//  FILTER_LEN  3   consecutive stable samples before the filtered line toggles, minimum 1
//  TIMEOUT_W   20  width of the response-timeout counter
// PORTS
//  aclk           in   1          clock
//  aresetn        in   1          asynchronous reset, active low
//  enable         in   1          PHY enable from the control register
//  loopback_en    in   1          route tx_sdck* to rx_sdck*; all pins released
//  port_sel       in   PORT_W     requested port, sampled at transaction start
//  timeout_cycles in   TIMEOUT_W  response window in cycles; 0 disables the timeout
//  tx_sdcka       in   1          transmitter SDCKA level
//  tx_sdckb       in   1          transmitter SDCKB level
//  tx_active      in   1          transmitter TRANSMITTING
//  rx_active      in   1          receiver RECEIVING
//  rx_sdcka       out  1          filtered SDCKA to the receiver
//  rx_sdckb       out  1          filtered SDCKB to the receiver
//  sdcka_i        in   NUM_PORTS  raw SDCKA pin levels
//  sdckb_i        in   NUM_PORTS  raw SDCKB pin levels
//  sdcka_oe       out  NUM_PORTS  1 = drive pin low; 0 = release to pull-up
//  sdckb_oe       out  NUM_PORTS  1 = drive pin low; 0 = release to pull-up
//  cur_port       out  PORT_W     latched active port
//  busy           out  1          FSM not in IDLE
//  timeout_pulse  out  1          one-cycle pulse when the response window expires
// BEHAVIOUR
//  Reset values: FSM IDLE, cur_port 0, all sync and filter flops 1, filter counter 0, timeout counter 0.
//   - Outputs: rx_sdcka=1, rx_sdckb=1, *_oe=0, busy=0, timeout_pulse=0.
//  FSM states: IDLE, TX, WAIT_RESP, RX. All transitions are registered.
//  IDLE:
//   - cur_port <= port_sel every cycle.
//   - enable & tx_active -> TX; cur_port is frozen from that edge.
//  TX:
//   - sdcka_oe[cur_port] = ~tx_sdcka and sdckb_oe[cur_port] = ~tx_sdckb (combinational); all other oe bits 0.
//   - rx_sdck* is forced to 1; rx_active is ignored.
//   - Falling tx_active -> WAIT_RESP; timeout counter <= timeout_cycles.
//  WAIT_RESP:
//   - Counter decrements each cycle.
//   - rx_active -> RX.
//   - Counter ==1 and no rx_active -> IDLE with timeout_pulse=1 on that transition edge, i.e. exactly timeout_cycles cycles after entry.
//   - rx_active wins over simultaneous expiry.
//   - timeout_cycles==0: wait indefinitely.
//   - tx_active -> TX with no pulse.
//  RX:
//   - Falling rx_active -> IDLE.
//  enable=0 in any state:
//   - Next edge -> IDLE; *_oe go to 0 combinationally at once; no timeout_pulse.
//  port_sel changes outside IDLE are ignored.
//  Input path:
//   - Each pin passes through SYNC_STAGES flops.
//   - The synced pair of cur_port is muxed into one shared filter per line.
//   - The filter output toggles on the edge where the synced value has differed for FILTER_LEN consecutive samples; any agreeing sample clears the counter.
//   - Pin-to-rx_sdck latency = SYNC_STAGES+FILTER_LEN cycles.
//   - A cur_port change re-seeds both filter outputs from the new port's synced values and clears the counters.
//  Loopback (loopback_en=1):
//   - All oe bits are 0.
//   - rx_sdck* = tx_sdck* combinationally, bypassing sync and filter.
//   - FSM operates normally.
//  Reset asserted mid-transaction: immediate return to reset values, pins released asynchronously.
// TESTING
//  1. Tx on port 2: port_sel=2, tx_active 1 for 50 cycles toggling tx_sdcka -> only sdcka_oe[2] follows ~tx_sdcka; other oe bits 0; rx_sdck* stay 1.
//  2. Response timeout: timeout_cycles=100, tx ends, no rx_active -> timeout_pulse exactly 100 cycles after WAIT_RESP entry, busy drops with it.
//  3. Response received: rx_active rises 40 cycles into WAIT_RESP -> RX, no pulse; rx_active rises on the expiry cycle -> RX, no pulse.
//  4. Glitch rejection: FILTER_LEN=3, 2-cycle low glitch on sdcka_i[cur_port] -> rx_sdcka stays 1; a 3-cycle low falls after 5 cycles.
//  5. Loopback: loopback_en=1 with a 10-byte transmit -> rx_sdck* equal tx_sdck* cycle-for-cycle and all oe bits 0.
//  6. Disruptions: port_sel 1->3 during TX -> cur_port stays 1; enable=0 in WAIT_RESP -> IDLE, no pulse; aresetn low mid-TX -> oe=0 at once.

Source files
------------

// File: rtl/maple_port_phy.sv
// Multi-port Maple Bus PHY: port steering, pin synchronisers and glitch filter,
// host-send / device-response turnaround FSM with timeout, and loopback.
module maple_port_phy #(
  parameter int NUM_PORTS   = 4,
  parameter int PORT_W      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int TIMEOUT_W   = 20
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic                 loopback_en,
  input  logic [PORT_W-1:0]    port_sel,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic                 tx_sdcka,
  input  logic                 tx_sdckb,
  input  logic                 tx_active,
  input  logic                 rx_active,
  output logic                 rx_sdcka,
  output logic                 rx_sdckb,
  input  logic [NUM_PORTS-1:0] sdcka_i,
  input  logic [NUM_PORTS-1:0] sdckb_i,
  output logic [NUM_PORTS-1:0] sdcka_oe,
  output logic [NUM_PORTS-1:0] sdckb_oe,
  output logic [PORT_W-1:0]    cur_port,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILTER_LEN - 1);

  typedef enum logic [1:0] {IDLE, TX, WAIT_RESP, RX} state_t;

  state_t               state, state_nxt;
  logic [PORT_W-1:0]    port_nxt;
  logic [TIMEOUT_W-1:0] tcnt, tcnt_nxt;
  logic                 pulse_nxt;

  logic [NUM_PORTS-1:0] sync_a [SYNC_STAGES];
  logic [NUM_PORTS-1:0] sync_b [SYNC_STAGES];
  logic                 synced_cur_a, synced_cur_b, synced_nxt_a, synced_nxt_b;
  logic                 filt_a, filt_b;
  logic [FCNT_W-1:0]    fcnt_a, fcnt_b;

  // ---------------- FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      cur_port      <= '0;
      tcnt          <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cur_port      <= port_nxt;
      tcnt          <= tcnt_nxt;
      timeout_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    port_nxt  = (state == IDLE) ? port_sel : cur_port;
    tcnt_nxt  = tcnt;
    pulse_nxt = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (tx_active) state_nxt = TX;
        TX: if (!tx_active) begin
          state_nxt = WAIT_RESP;
          tcnt_nxt  = timeout_cycles;
        end
        WAIT_RESP: begin
          // A zero count never reaches 1, so timeout_cycles==0 waits forever.
          if (tcnt != '0) tcnt_nxt = tcnt - 1'b1;
          if (tx_active) begin
            state_nxt = TX;
          end else if (rx_active) begin
            state_nxt = RX;
          end else if (tcnt == TIMEOUT_W'(1)) begin
            state_nxt = IDLE;
            pulse_nxt = 1'b1;
          end
        end
        RX: if (!rx_active) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // ---------------- Input path ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_a[s] <= '1;
        sync_b[s] <= '1;
      end
    end else begin
      sync_a[0] <= sdcka_i;
      sync_b[0] <= sdckb_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_a[s] <= sync_a[s-1];
        sync_b[s] <= sync_b[s-1];
      end
    end
  end

  always_comb begin
    synced_cur_a = 1'b1;
    synced_cur_b = 1'b1;
    synced_nxt_a = 1'b1;
    synced_nxt_b = 1'b1;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (PORT_W'(i) == cur_port) begin
        synced_cur_a = sync_a[SYNC_STAGES-1][i];
        synced_cur_b = sync_b[SYNC_STAGES-1][i];
      end
      if (PORT_W'(i) == port_nxt) begin
        synced_nxt_a = sync_a[SYNC_STAGES-1][i];
        synced_nxt_b = sync_b[SYNC_STAGES-1][i];
      end
    end
  end

  // One shared filter per line; a port switch reseeds it from the new port.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      filt_a <= 1'b1;
      filt_b <= 1'b1;
      fcnt_a <= '0;
      fcnt_b <= '0;
    end else if (port_nxt != cur_port) begin
      filt_a <= synced_nxt_a;
      filt_b <= synced_nxt_b;
      fcnt_a <= '0;
      fcnt_b <= '0;
    end else begin
      if (synced_cur_a == filt_a) begin
        fcnt_a <= '0;
      end else if (fcnt_a == FCNT_MAX) begin
        filt_a <= synced_cur_a;
        fcnt_a <= '0;
      end else begin
        fcnt_a <= fcnt_a + 1'b1;
      end
      if (synced_cur_b == filt_b) begin
        fcnt_b <= '0;
      end else if (fcnt_b == FCNT_MAX) begin
        filt_b <= synced_cur_b;
        fcnt_b <= '0;
      end else begin
        fcnt_b <= fcnt_b + 1'b1;
      end
    end
  end

  // ---------------- Outputs ----------------
  always_comb begin
    sdcka_oe = '0;
    sdckb_oe = '0;
    if (state == TX && enable && !loopback_en) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (PORT_W'(i) == cur_port) begin
          sdcka_oe[i] = ~tx_sdcka;
          sdckb_oe[i] = ~tx_sdckb;
        end
      end
    end
  end

  always_comb begin
    if (loopback_en) begin
      rx_sdcka = tx_sdcka;
      rx_sdckb = tx_sdckb;
    end else if (state == TX) begin
      rx_sdcka = 1'b1;
      rx_sdckb = 1'b1;
    end else begin
      rx_sdcka = filt_a;
      rx_sdckb = filt_b;
    end
  end

endmodule

// File: tb/tb_maple_port_phy.sv
// Directed bench for maple_port_phy with default parameters.
module tb_maple_port_phy;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        loopback_en;
  logic [1:0]  port_sel;
  logic [19:0] timeout_cycles;
  logic        tx_sdcka, tx_sdckb, tx_active, rx_active;
  logic        rx_sdcka, rx_sdckb;
  logic [3:0]  sdcka_i, sdckb_i, sdcka_oe, sdckb_oe;
  logic [1:0]  cur_port;
  logic        busy, timeout_pulse;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  maple_port_phy #(
    .NUM_PORTS(4), .PORT_W(2), .SYNC_STAGES(2), .FILTER_LEN(3), .TIMEOUT_W(20)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .loopback_en(loopback_en),
    .port_sel(port_sel), .timeout_cycles(timeout_cycles),
    .tx_sdcka(tx_sdcka), .tx_sdckb(tx_sdckb), .tx_active(tx_active), .rx_active(rx_active),
    .rx_sdcka(rx_sdcka), .rx_sdckb(rx_sdckb), .sdcka_i(sdcka_i), .sdckb_i(sdckb_i),
    .sdcka_oe(sdcka_oe), .sdckb_oe(sdckb_oe), .cur_port(cur_port), .busy(busy),
    .timeout_pulse(timeout_pulse)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] bytes [10];
    logic [3:0] exp_oe;

    aresetn = 1'b0; enable = 1'b1; loopback_en = 1'b0; port_sel = 2'd0;
    timeout_cycles = 20'd100; tx_sdcka = 1'b1; tx_sdckb = 1'b1;
    tx_active = 1'b0; rx_active = 1'b0; sdcka_i = '1; sdckb_i = '1;
    tick(); tick();
    chk("rst_rx_a", {31'd0, rx_sdcka}, 32'd1);
    chk("rst_rx_b", {31'd0, rx_sdckb}, 32'd1);
    chk("rst_oe", {24'd0, sdcka_oe, sdckb_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulse", {31'd0, timeout_pulse}, 32'd0);
    chk("rst_port", {30'd0, cur_port}, 32'd0);
    aresetn = 1'b1;
    tick();

    // 1. transmit on port 2
    port_sel = 2'd2;
    tick();
    chk("idle_port", {30'd0, cur_port}, 32'd2);
    tx_active = 1'b1;
    tick();
    chk("tx_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 50; i++) begin
      tx_sdcka = i[0];
      #1;
      exp_oe = tx_sdcka ? 4'b0000 : 4'b0100;
      chk("tx_oe_a", {28'd0, sdcka_oe}, {28'd0, exp_oe});
      chk("tx_oe_b", {28'd0, sdckb_oe}, 32'd0);
      chk("tx_rx_forced", {30'd0, rx_sdcka, rx_sdckb}, 32'd3);
      tick();
    end

    // 2. response timeout after exactly 100 cycles
    tx_sdcka = 1'b1; tx_active = 1'b0;
    tick();
    for (int i = 1; i < 100; i++) begin
      tick();
      chk("wait_nopulse", {30'd0, busy, timeout_pulse}, 32'd2);
    end
    tick();
    chk("timeout_edge", {30'd0, busy, timeout_pulse}, 32'd1);
    tick();
    chk("pulse_oneshot", {31'd0, timeout_pulse}, 32'd0);

    // 3a. response 40 cycles into the window
    tx_active = 1'b1; tick();
    tx_active = 1'b0; tick();
    for (int i = 0; i < 40; i++) tick();
    rx_active = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      chk("rx_hold", {30'd0, busy, timeout_pulse}, 32'd2);
    end
    rx_active = 1'b0; tick();
    chk("rx_end", {30'd0, busy, timeout_pulse}, 32'd0);

    // 3b. response on the expiry cycle wins
    tx_active = 1'b1; tick();
    tx_active = 1'b0; tick();
    for (int i = 1; i < 100; i++) tick();
    rx_active = 1'b1; tick();
    chk("rx_on_expiry", {30'd0, busy, timeout_pulse}, 32'd2);
    rx_active = 1'b0; tick();
    chk("rx_on_expiry_end", {30'd0, busy, timeout_pulse}, 32'd0);

    // 4. glitch filter on port 2
    sdcka_i[2] = 1'b0; tick(); tick(); sdcka_i[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("glitch_reject", {31'd0, rx_sdcka}, 32'd1);
    end
    sdcka_i[2] = 1'b0; tick(); tick(); tick(); sdcka_i[2] = 1'b1;
    tick();
    chk("low_before_edge5", {31'd0, rx_sdcka}, 32'd1);
    tick();
    chk("low_at_edge5", {31'd0, rx_sdcka}, 32'd0);
    tick(); tick();
    chk("low_held", {31'd0, rx_sdcka}, 32'd0);
    tick();
    chk("high_restored", {31'd0, rx_sdcka}, 32'd1);

    // port switch reseeds the filter immediately
    sdckb_i[1] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("other_port_ignored", {31'd0, rx_sdckb}, 32'd1);
    port_sel = 2'd1; tick();
    chk("reseed_to_p1", {31'd0, rx_sdckb}, 32'd0);
    sdckb_i[1] = 1'b1; port_sel = 2'd2; tick();
    chk("reseed_to_p2", {31'd0, rx_sdckb}, 32'd1);
    tick(); tick(); tick();

    // 5. loopback over a 10-byte transmit
    loopback_en = 1'b1; port_sel = 2'd0;
    for (int i = 0; i < 10; i++) bytes[i] = 8'h3c + 8'(i * 37);
    tx_active = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tx_sdcka = bytes[i/8][i%8];
      tx_sdckb = ~bytes[i/8][(i+3)%8];
      #1;
      chk("lb_rx", {30'd0, rx_sdcka, rx_sdckb}, {30'd0, tx_sdcka, tx_sdckb});
      chk("lb_oe", {24'd0, sdcka_oe, sdckb_oe}, 32'd0);
      tick();
    end
    chk("lb_fsm_busy", {31'd0, busy}, 32'd1);
    tx_sdcka = 1'b1; tx_sdckb = 1'b1; tx_active = 1'b0; tick();
    loopback_en = 1'b0;

    // 6. enable drop in WAIT_RESP
    for (int i = 0; i < 10; i++) tick();
    chk("wait_busy", {31'd0, busy}, 32'd1);
    enable = 1'b0; tick();
    chk("dis_idle", {30'd0, busy, timeout_pulse}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("dis_nopulse", {31'd0, timeout_pulse}, 32'd0);
    end
    enable = 1'b1;

    // timeout_cycles == 0 waits indefinitely
    timeout_cycles = 20'd0;
    tx_active = 1'b1; tick(); tx_active = 1'b0; tick();
    for (int i = 0; i < 300; i++) tick();
    chk("no_timeout", {30'd0, busy, timeout_pulse}, 32'd2);
    enable = 1'b0; tick(); enable = 1'b1;
    chk("no_timeout_exit", {31'd0, busy}, 32'd0);

    // port_sel change during TX is ignored
    timeout_cycles = 20'd100;
    port_sel = 2'd1; tick();
    tx_active = 1'b1; tick();
    port_sel = 2'd3; tick();
    chk("port_frozen", {30'd0, cur_port}, 32'd1);
    tx_sdcka = 1'b0; #1;
    chk("tx_p1_oe", {28'd0, sdcka_oe}, 32'h2);
    enable = 1'b0; #1;
    chk("dis_oe_comb", {28'd0, sdcka_oe}, 32'h0);
    enable = 1'b1; #1;
    chk("reen_oe", {28'd0, sdcka_oe}, 32'h2);

    // asynchronous reset mid-TX
    #2 aresetn = 1'b0; #1;
    chk("arst_oe", {24'd0, sdcka_oe, sdckb_oe}, 32'd0);
    chk("arst_state", {29'd0, busy, cur_port}, 32'd0);
    tick();
    aresetn = 1'b1; tx_active = 1'b0; tx_sdcka = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
